// File: rtl/lcd_pkg.sv
// Shared encodings for the character-LCD controller: write ops, wait classes,
// HD44780 command bytes and the FSM state types.
package lcd_pkg;

  typedef enum logic [1:0] {
    OP_CHAR  = 2'b00,
    OP_CLEAR = 2'b01,
    OP_GOTO  = 2'b10,
    OP_RSVD  = 2'b11
  } lcd_op_e;

  typedef enum logic [1:0] {
    W_CMD   = 2'd0,
    W_CLEAR = 2'd1,
    W_INIT  = 2'd2
  } lcd_wait_e;

  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] CMD_WAKE     = 8'h30;
  localparam logic [7:0] CMD_SET4     = 8'h20;
  localparam logic [7:0] CMD_SET_ADDR = 8'h80;
  localparam logic [7:0] LINE1_BASE   = 8'h40;

  typedef enum logic [4:0] {
    S_IDLE, S_PWR_WAIT, S_WAKE1, S_WAKE2, S_WAKE3, S_SET4,
    S_FUNC_SET, S_ENTRY, S_DISP_ON, S_CLEAR, S_HOME_ADDR,
    S_READY, S_WRITE_CHAR, S_CLR_CMD, S_ADDR_CMD, S_WRAP_ADDR, S_DROP
  } lcd_state_e;

  typedef enum logic [2:0] {
    X_IDLE, X_SETUP, X_PULSE, X_HOLD, X_WAIT
  } lcd_xstate_e;

  // Down-counter reload value; a requested length of 0 still lasts one cycle.
  function automatic logic [31:0] cyc_load(input logic [31:0] n);
    return (n <= 32'd1) ? 32'd0 : n - 32'd1;
  endfunction

endpackage

// File: rtl/lcd_xfer.sv
// Byte/nibble transfer engine: setup, enable pulse, hold, then a post-write
// wait; done pulses on the last wait cycle.
module lcd_xfer
  import lcd_pkg::*;
#(
  parameter int unsigned SETUP_CYC    = 2,
  parameter int unsigned E_CYC        = 12,
  parameter int unsigned CMD_CYC      = 2000,
  parameter int unsigned CLEAR_CYC    = 82000,
  parameter int unsigned INIT_GAP_CYC = 205000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        go_i,
  input  logic [7:0]  byte_i,
  input  logic        rs_i,
  input  logic        nib_only_i,
  input  logic        bus4_i,
  input  lcd_wait_e   wait_sel_i,
  output logic [7:0]  lcd_db_o,
  output logic        lcd_e_o,
  output logic        lcd_rs_o,
  output logic        done_o,
  output lcd_xstate_e state_o
);

  lcd_xstate_e state_q, state_d;
  logic [31:0] cnt_q, cnt_d, wait_load;
  logic [7:0]  byte_q, byte_d, bus;
  logic        rs_q, rs_d, lo_q, lo_d, two_q, two_d, active;
  lcd_wait_e   wsel_q, wsel_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= X_IDLE;
      cnt_q   <= '0;
      byte_q  <= '0;
      rs_q    <= 1'b0;
      lo_q    <= 1'b0;
      two_q   <= 1'b0;
      wsel_q  <= W_CMD;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      byte_q  <= byte_d;
      rs_q    <= rs_d;
      lo_q    <= lo_d;
      two_q   <= two_d;
      wsel_q  <= wsel_d;
    end
  end

  always_comb begin
    unique case (wsel_q)
      W_CLEAR: wait_load = cyc_load(CLEAR_CYC);
      W_INIT:  wait_load = cyc_load(INIT_GAP_CYC);
      default: wait_load = cyc_load(CMD_CYC);
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    byte_d  = byte_q;
    rs_d    = rs_q;
    lo_d    = lo_q;
    two_d   = two_q;
    wsel_d  = wsel_q;
    done_o  = 1'b0;
    unique case (state_q)
      X_IDLE: if (go_i) begin
        state_d = X_SETUP;
        cnt_d   = cyc_load(SETUP_CYC);
        byte_d  = byte_i;
        rs_d    = rs_i;
        lo_d    = 1'b0;
        two_d   = bus4_i && !nib_only_i;
        wsel_d  = wait_sel_i;
      end
      X_SETUP: if (cnt_q == '0) begin
        state_d = X_PULSE;
        cnt_d   = cyc_load(E_CYC);
      end else cnt_d = cnt_q - 32'd1;
      X_PULSE: if (cnt_q == '0) begin
        state_d = X_HOLD;
        cnt_d   = cyc_load(E_CYC);
      end else cnt_d = cnt_q - 32'd1;
      // In 4-bit mode a full byte loops back once for its low nibble.
      X_HOLD: if (cnt_q == '0) begin
        if (two_q && !lo_q) begin
          lo_d    = 1'b1;
          state_d = X_SETUP;
          cnt_d   = cyc_load(SETUP_CYC);
        end else begin
          state_d = X_WAIT;
          cnt_d   = wait_load;
        end
      end else cnt_d = cnt_q - 32'd1;
      X_WAIT: if (cnt_q == '0) begin
        done_o  = 1'b1;
        state_d = X_IDLE;
      end else cnt_d = cnt_q - 32'd1;
      default: state_d = X_IDLE;
    endcase
  end

  assign bus      = bus4_i ? {(lo_q ? byte_q[3:0] : byte_q[7:4]), 4'h0} : byte_q;
  assign active   = (state_q == X_SETUP) || (state_q == X_PULSE) || (state_q == X_HOLD);
  assign lcd_db_o = active ? bus : 8'h00;
  assign lcd_rs_o = active && rs_q;
  assign lcd_e_o  = (state_q == X_PULSE);
  assign state_o  = state_q;

endmodule

// File: rtl/lcd_char_ctrl.sv
// Character-LCD controller top: power-up/init sequencer, valid/ready write
// port and cursor tracking, all sharing one lcd_xfer engine.
module lcd_char_ctrl
  import lcd_pkg::*;
#(
  parameter int unsigned BUS4         = 0,
  parameter int unsigned NUM_LINES    = 2,
  parameter int unsigned LINE_LEN     = 16,
  parameter int unsigned POWERUP_CYC  = 750000,
  parameter int unsigned INIT_GAP_CYC = 205000,
  parameter int unsigned CMD_CYC      = 2000,
  parameter int unsigned CLEAR_CYC    = 82000,
  parameter int unsigned SETUP_CYC    = 2,
  parameter int unsigned E_CYC        = 12
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        wr_valid_i,
  output logic        wr_ready_o,
  input  logic [1:0]  wr_op_i,
  input  logic [7:0]  wr_data_i,
  output logic        init_done_o,
  output logic        cur_line_o,
  output logic [5:0]  cur_col_o,
  output logic [7:0]  lcd_db_o,
  output logic        lcd_e_o,
  output logic        lcd_rs_o,
  output logic        lcd_rw_o,
  output lcd_state_e  dbg_state_o,
  output lcd_xstate_e dbg_xfer_state_o
);

  localparam logic [7:0] FUNC_SET_CMD = 8'h20 | ((BUS4 != 0) ? 8'h00 : 8'h10)
                                              | ((NUM_LINES == 2) ? 8'h08 : 8'h00);
  localparam logic [5:0] LAST_COL = 6'(LINE_LEN - 1);

  lcd_state_e  state_q, state_d;
  logic [31:0] pwr_q, pwr_d;
  logic        busy_q, busy_d, init_done_q, init_done_d, cur_line_q, cur_line_d;
  logic [5:0]  cur_col_q, cur_col_d, goto_col;
  logic [7:0]  data_q, data_d, x_byte;
  logic        goto_line, is_cmd, go, x_rs, x_nib, xfer_done;
  lcd_wait_e   x_wait;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      pwr_q       <= '0;
      busy_q      <= 1'b0;
      init_done_q <= 1'b0;
      cur_line_q  <= 1'b0;
      cur_col_q   <= '0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      pwr_q       <= pwr_d;
      busy_q      <= busy_d;
      init_done_q <= init_done_d;
      cur_line_q  <= cur_line_d;
      cur_col_q   <= cur_col_d;
      data_q      <= data_d;
    end
  end

  assign goto_col  = (wr_data_i[5:0] > LAST_COL) ? LAST_COL : wr_data_i[5:0];
  assign goto_line = wr_data_i[7] && (NUM_LINES == 2);

  // Byte, register select and wait class for whichever state owns the engine.
  always_comb begin
    is_cmd = 1'b1;
    x_byte = 8'h00;
    x_rs   = 1'b0;
    x_nib  = 1'b0;
    x_wait = W_CMD;
    unique case (state_q)
      S_WAKE1, S_WAKE2: begin x_byte = CMD_WAKE; x_nib = 1'b1; x_wait = W_INIT; end
      S_WAKE3:          begin x_byte = CMD_WAKE; x_nib = 1'b1; end
      S_SET4:           begin x_byte = CMD_SET4; x_nib = 1'b1; end
      S_FUNC_SET:       x_byte = FUNC_SET_CMD;
      S_ENTRY:          x_byte = CMD_ENTRY;
      S_DISP_ON:        x_byte = CMD_DISP_ON;
      S_CLEAR, S_CLR_CMD: begin x_byte = CMD_CLEAR; x_wait = W_CLEAR; end
      S_HOME_ADDR:      x_byte = CMD_SET_ADDR;
      S_WRITE_CHAR:     begin x_byte = data_q; x_rs = 1'b1; end
      S_ADDR_CMD:       x_byte = data_q;
      S_WRAP_ADDR:      x_byte = CMD_SET_ADDR | (cur_line_q ? LINE1_BASE : 8'h00);
      default:          is_cmd = 1'b0;
    endcase
  end

  assign go = is_cmd && !busy_q;

  always_comb begin
    state_d     = state_q;
    pwr_d       = pwr_q;
    busy_d      = busy_q;
    init_done_d = init_done_q;
    cur_line_d  = cur_line_q;
    cur_col_d   = cur_col_q;
    data_d      = data_q;
    if (go)        busy_d = 1'b1;
    if (xfer_done) busy_d = 1'b0;
    unique case (state_q)
      S_IDLE: if (start_i) begin
        state_d = S_PWR_WAIT;
        pwr_d   = cyc_load(POWERUP_CYC);
      end
      S_PWR_WAIT: if (pwr_q == '0) state_d = S_WAKE1;
                  else pwr_d = pwr_q - 32'd1;
      S_WAKE1:    if (xfer_done) state_d = S_WAKE2;
      S_WAKE2:    if (xfer_done) state_d = S_WAKE3;
      S_WAKE3:    if (xfer_done) state_d = (BUS4 != 0) ? S_SET4 : S_FUNC_SET;
      S_SET4:     if (xfer_done) state_d = S_FUNC_SET;
      S_FUNC_SET: if (xfer_done) state_d = S_ENTRY;
      S_ENTRY:    if (xfer_done) state_d = S_DISP_ON;
      S_DISP_ON:  if (xfer_done) state_d = S_CLEAR;
      S_CLEAR:    if (xfer_done) state_d = S_HOME_ADDR;
      S_HOME_ADDR: if (xfer_done) begin
        state_d     = S_READY;
        init_done_d = 1'b1;
        cur_line_d  = 1'b0;
        cur_col_d   = '0;
      end
      // A goto latches the finished set-address byte; its cursor lives in [6] and [5:0].
      S_READY: if (wr_valid_i) begin
        unique case (wr_op_i)
          OP_CHAR:  begin data_d = wr_data_i; state_d = S_WRITE_CHAR; end
          OP_CLEAR: state_d = S_CLR_CMD;
          OP_GOTO:  begin
            data_d  = CMD_SET_ADDR | (goto_line ? LINE1_BASE : 8'h00) | {2'b00, goto_col};
            state_d = S_ADDR_CMD;
          end
          default:  state_d = S_DROP;
        endcase
      end
      S_WRITE_CHAR: if (xfer_done) begin
        if (cur_col_q == LAST_COL) begin
          cur_col_d  = '0;
          cur_line_d = (NUM_LINES == 2) ? ~cur_line_q : 1'b0;
          state_d    = S_WRAP_ADDR;
        end else begin
          cur_col_d = cur_col_q + 6'd1;
          state_d   = S_READY;
        end
      end
      S_CLR_CMD: if (xfer_done) begin
        cur_line_d = 1'b0;
        cur_col_d  = '0;
        state_d    = S_READY;
      end
      S_ADDR_CMD: if (xfer_done) begin
        cur_line_d = data_q[6];
        cur_col_d  = data_q[5:0];
        state_d    = S_READY;
      end
      S_WRAP_ADDR: if (xfer_done) state_d = S_READY;
      S_DROP:      state_d = S_READY;
      default:     state_d = S_IDLE;
    endcase
  end

  lcd_xfer #(
    .SETUP_CYC(SETUP_CYC), .E_CYC(E_CYC), .CMD_CYC(CMD_CYC),
    .CLEAR_CYC(CLEAR_CYC), .INIT_GAP_CYC(INIT_GAP_CYC)
  ) u_xfer (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .go_i       (go),
    .byte_i     (x_byte),
    .rs_i       (x_rs),
    .nib_only_i (x_nib),
    .bus4_i     (BUS4 != 0),
    .wait_sel_i (x_wait),
    .lcd_db_o   (lcd_db_o),
    .lcd_e_o    (lcd_e_o),
    .lcd_rs_o   (lcd_rs_o),
    .done_o     (xfer_done),
    .state_o    (dbg_xfer_state_o)
  );

  assign wr_ready_o  = (state_q == S_READY);
  assign init_done_o = init_done_q;
  assign cur_line_o  = cur_line_q;
  assign cur_col_o   = cur_col_q;
  assign lcd_rw_o    = 1'b0;
  assign dbg_state_o = state_q;

endmodule
